// File: rtl/pipeline_stall_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_stall_sequencer
//
// Purpose:
//   Central stall / flush / freeze controller for the 5-stage MIPS pipeline.
//   It merges four kinds of request into one set of pipeline-register write
//   enables and flush strobes:
//     - load-use stalls from the hazard detection unit
//     - taken-branch flushes
//     - multi-cycle mul/div occupancy of EX
//     - HALT drain
//   It also obeys the debug unit's run / step / stop commands.
//
// Parameters:
//   MD_LATENCY    cycles a mul/div op occupies EX (2..16)
//   DRAIN_CYCLES  cycles given to in-flight instructions after HALT (1..16)
//
// Ports:
//   i_clk             system clock, rising edge
//   i_rst             synchronous reset, active-high
//   i_load_use_stall  load-use hazard request
//   i_branch_taken    branch/jump resolved taken in ID
//   i_md_start        mul/div op entering EX
//   i_halt_id         HALT decoded in ID
//   i_dbg_run         debug free-run request
//   i_dbg_step        debug single-cycle advance request
//   i_dbg_stop        debug return-to-frozen request
//   o_pc_we           PC write enable
//   o_if_id_we        IF/ID write enable
//   o_if_id_flush     IF/ID clear (NOP)
//   o_id_ex_we        ID/EX write enable
//   o_id_ex_flush     ID/EX clear (bubble)
//   o_ex_mem_flush    EX/MEM clear (bubble)
//   o_pipe_en         global enable for EX/MEM, MEM/WB, RF and memory writes
//   o_halted          registered, high while HALTED
//   o_step_done       registered, one-cycle pulse when a debug step completes
//   o_state           current state encoding for debug readout
// ---------------------------------------------------------------------------
module pipeline_stall_sequencer #(
  parameter int MD_LATENCY   = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load_use_stall,
  input  logic       i_branch_taken,
  input  logic       i_md_start,
  input  logic       i_halt_id,
  input  logic       i_dbg_run,
  input  logic       i_dbg_step,
  input  logic       i_dbg_stop,
  output logic       o_pc_we,
  output logic       o_if_id_we,
  output logic       o_if_id_flush,
  output logic       o_id_ex_we,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_flush,
  output logic       o_pipe_en,
  output logic       o_halted,
  output logic       o_step_done,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    MD_WAIT = 3'd3,
    DRAIN   = 3'd4,
    HALTED  = 3'd5
  } state_t;

  // The mul/div op spends one cycle holding in RUN/STEP before MD_WAIT, and
  // MD_WAIT exits on the cycle its counter reads 0, hence the -2.
  localparam logic [3:0] MD_LOAD    = 4'(MD_LATENCY - 2);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_count;
  logic       r_stopPend;
  logic       r_fromStep;
  logic       r_halted;
  logic       r_stepDone;

  logic       w_active;
  logic       w_ruleHalt;
  logic       w_ruleStall;
  logic       w_ruleMd;
  logic       w_ruleBranch;

  // Priority decode of the hazard requests. Only meaningful while the
  // pipeline is actively advancing (RUN or STEP). A HALT hidden behind a
  // load-use stall waits for the stall to clear. A stall masks both the
  // branch and the mul/div start, since the instruction in ID is not
  // advancing that cycle. Branch and mul/div may fire together.
  always_comb begin
    w_active     = (r_state == RUN) || (r_state == STEP);
    w_ruleHalt   = w_active && i_halt_id && !i_load_use_stall;
    w_ruleStall  = w_active && i_load_use_stall;
    w_ruleMd     = w_active && i_md_start && !i_load_use_stall && !i_halt_id;
    w_ruleBranch = w_active && i_branch_taken && !i_load_use_stall && !i_halt_id;
  end

  // Combinational enable/flush generation from the current state and the
  // decoded rules. Everything defaults to frozen, which covers IDLE and
  // HALTED. Each active state then opens up only what it needs.
  always_comb begin
    o_pc_we        = 1'b0;
    o_if_id_we     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_we     = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_pipe_en      = 1'b0;
    case (r_state)
      RUN, STEP: begin
        o_pipe_en  = 1'b1;
        o_pc_we    = 1'b1;
        o_if_id_we = 1'b1;
        o_id_ex_we = 1'b1;
        if (w_ruleHalt) begin
          // Stop fetching and replace whatever follows HALT with a NOP.
          o_pc_we       = 1'b0;
          o_if_id_flush = 1'b1;
        end else if (w_ruleStall) begin
          o_pc_we       = 1'b0;
          o_if_id_we    = 1'b0;
          o_id_ex_flush = 1'b1;
        end else begin
          if (w_ruleMd) begin
            o_pc_we    = 1'b0;
            o_if_id_we = 1'b0;
            o_id_ex_we = 1'b0;
          end
          if (w_ruleBranch) begin
            o_if_id_flush = 1'b1;
          end
        end
      end
      MD_WAIT: begin
        // EX is busy, so everything upstream holds and bubbles go downstream.
        o_pipe_en      = 1'b1;
        o_ex_mem_flush = 1'b1;
      end
      DRAIN: begin
        // Older instructions keep retiring. Bubbles enter behind them.
        o_pipe_en     = 1'b1;
        o_id_ex_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State machine, shared 4-bit counter and the registered status flags.
  // The counter only ever decrements while nonzero, so it saturates at 0.
  // r_stopPend remembers a debug stop that arrived while a mul/div or HALT
  // took precedence. r_fromStep remembers that MD_WAIT was entered from a
  // single step, so the step_done pulse is owed when it finishes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_stopPend <= 1'b0;
      r_fromStep <= 1'b0;
      r_halted   <= 1'b0;
      r_stepDone <= 1'b0;
    end else begin
      r_stepDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_dbg_run) begin
            r_state <= RUN;
          end else if (i_dbg_step) begin
            r_state <= STEP;
          end
        end
        RUN: begin
          if (w_ruleHalt) begin
            r_state <= DRAIN;
            r_count <= DRAIN_LOAD;
            if (i_dbg_stop) begin
              r_stopPend <= 1'b1;
            end
          end else if (w_ruleMd) begin
            r_state    <= MD_WAIT;
            r_count    <= MD_LOAD;
            r_fromStep <= 1'b0;
            if (i_dbg_stop) begin
              r_stopPend <= 1'b1;
            end
          end else if (i_dbg_stop) begin
            r_state <= IDLE;
          end
        end
        STEP: begin
          if (w_ruleHalt) begin
            r_state <= DRAIN;
            r_count <= DRAIN_LOAD;
          end else if (w_ruleMd) begin
            r_state    <= MD_WAIT;
            r_count    <= MD_LOAD;
            r_stopPend <= 1'b1;
            r_fromStep <= 1'b1;
          end else begin
            r_state    <= IDLE;
            r_stepDone <= 1'b1;
          end
        end
        MD_WAIT: begin
          if (r_count == 4'd0) begin
            if (r_stopPend || i_dbg_stop) begin
              r_state    <= IDLE;
              r_stopPend <= 1'b0;
              r_fromStep <= 1'b0;
              r_stepDone <= r_fromStep;
            end else begin
              r_state <= RUN;
            end
          end else begin
            r_count <= r_count - 4'd1;
            if (i_dbg_stop) begin
              r_stopPend <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (r_count == 4'd0) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_halted    = r_halted;
  assign o_step_done = r_stepDone;
  assign o_state     = r_state;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_sequencer
//
// Directed-vector bench for pipeline_stall_sequencer (MD_LATENCY=4,
// DRAIN_CYCLES=4). Each stimulus cycle pushes its hand-computed expected
// output vector onto a queue. A separate monitor pops one entry per falling
// edge and compares it against the DUT outputs under a care mask.
//
// Output vector layout (12 bits):
//   [11] pc_we  [10] if_id_we  [9] if_id_flush  [8] id_ex_we
//   [7] id_ex_flush  [6] ex_mem_flush  [5] pipe_en  [4] halted
//   [3] step_done  [2:0] state
// ---------------------------------------------------------------------------
module tb_pipeline_stall_sequencer;

  logic       i_clk;
  logic       i_rst;
  logic       i_load_use_stall;
  logic       i_branch_taken;
  logic       i_md_start;
  logic       i_halt_id;
  logic       i_dbg_run;
  logic       i_dbg_step;
  logic       i_dbg_stop;
  logic       o_pc_we;
  logic       o_if_id_we;
  logic       o_if_id_flush;
  logic       o_id_ex_we;
  logic       o_id_ex_flush;
  logic       o_ex_mem_flush;
  logic       o_pipe_en;
  logic       o_halted;
  logic       o_step_done;
  logic [2:0] o_state;

  pipeline_stall_sequencer #(
    .MD_LATENCY  (4),
    .DRAIN_CYCLES(4)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_load_use_stall(i_load_use_stall),
    .i_branch_taken  (i_branch_taken),
    .i_md_start      (i_md_start),
    .i_halt_id       (i_halt_id),
    .i_dbg_run       (i_dbg_run),
    .i_dbg_step      (i_dbg_step),
    .i_dbg_stop      (i_dbg_stop),
    .o_pc_we         (o_pc_we),
    .o_if_id_we      (o_if_id_we),
    .o_if_id_flush   (o_if_id_flush),
    .o_id_ex_we      (o_id_ex_we),
    .o_id_ex_flush   (o_id_ex_flush),
    .o_ex_mem_flush  (o_ex_mem_flush),
    .o_pipe_en       (o_pipe_en),
    .o_halted        (o_halted),
    .o_step_done     (o_step_done),
    .o_state         (o_state)
  );

  // Input selector bits: {rst, stall, branch, md, halt, run, step, stop}
  localparam logic [7:0] I_NONE  = 8'h00;
  localparam logic [7:0] I_RST   = 8'h80;
  localparam logic [7:0] I_STALL = 8'h40;
  localparam logic [7:0] I_BR    = 8'h20;
  localparam logic [7:0] I_MD    = 8'h10;
  localparam logic [7:0] I_HALT  = 8'h08;
  localparam logic [7:0] I_RUN   = 8'h04;
  localparam logic [7:0] I_STEP  = 8'h02;
  localparam logic [7:0] I_STOP  = 8'h01;

  // Hand-computed expected output vectors
  localparam logic [11:0] E_IDLE    = 12'b0000_0000_0000;
  localparam logic [11:0] E_IDLE_SD = 12'b0000_0000_1000;
  localparam logic [11:0] E_RUN     = 12'b1101_0010_0001;
  localparam logic [11:0] E_STALL   = 12'b0001_1010_0001;
  localparam logic [11:0] E_MDHOLD  = 12'b0000_0010_0001;
  localparam logic [11:0] E_MDWAIT  = 12'b0000_0110_0011;
  localparam logic [11:0] E_BR      = 12'b1111_0010_0001;
  localparam logic [11:0] E_BRMD    = 12'b0010_0010_0001;
  localparam logic [11:0] E_HALTRUN = 12'b0111_0010_0001;
  localparam logic [11:0] E_DRAIN   = 12'b0000_1010_0100;
  localparam logic [11:0] E_HALTED  = 12'b0000_0001_0101;
  localparam logic [11:0] E_STEP    = 12'b1101_0010_0010;
  localparam logic [11:0] E_STEPMD  = 12'b0000_0010_0010;

  localparam logic [11:0] M_ALL     = 12'hFFF;
  localparam logic [11:0] M_DRAIN   = 12'hEFF;

  typedef struct {
    string       name;
    logic [11:0] expected;
    logic [11:0] mask;
  } exp_t;

  exp_t expQ[$];
  int   checkCount;
  int   errorCount;

  // Free-running clock, 10 time units per cycle
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard stop in case anything stalls the run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one cycle of inputs just after the rising edge and queues the
  // outputs expected for that cycle.
  task automatic applyStimulus(input string name, input logic [7:0] sel,
                               input logic [11:0] expected, input logic [11:0] mask);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_rst            = sel[7];
    i_load_use_stall = sel[6];
    i_branch_taken   = sel[5];
    i_md_start       = sel[4];
    i_halt_id        = sel[3];
    i_dbg_run        = sel[2];
    i_dbg_step       = sel[1];
    i_dbg_stop       = sel[0];
    e.name     = name;
    e.expected = expected;
    e.mask     = mask;
    expQ.push_back(e);
  endtask

  // Compares one expected entry against the live DUT outputs
  task automatic checkOutput(input exp_t e);
    logic [11:0] actual;
    actual = {o_pc_we, o_if_id_we, o_if_id_flush, o_id_ex_we, o_id_ex_flush,
              o_ex_mem_flush, o_pipe_en, o_halted, o_step_done, o_state};
    checkCount++;
    if ((actual & e.mask) !== (e.expected & e.mask)) begin
      errorCount++;
      $display("[TB] FAIL %s: got %03h expected %03h (care %03h)",
               e.name, actual & e.mask, e.expected & e.mask, e.mask);
    end
  endtask

  // Monitor: on every falling edge, pop and compare the entry for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    checkCount       = 0;
    errorCount       = 0;
    i_rst            = 1'b1;
    i_load_use_stall = 1'b0;
    i_branch_taken   = 1'b0;
    i_md_start       = 1'b0;
    i_halt_id        = 1'b0;
    i_dbg_run        = 1'b0;
    i_dbg_step       = 1'b0;
    i_dbg_stop       = 1'b0;

    // Reset, then debug run
    applyStimulus("reset",          I_RST,           E_IDLE,    M_ALL);
    applyStimulus("idle_run_req",   I_RUN,           E_IDLE,    M_ALL);
    applyStimulus("run_defaults",   I_NONE,          E_RUN,     M_ALL);
    // Load-use beats branch
    applyStimulus("stall_over_br",  I_STALL | I_BR,  E_STALL,   M_ALL);
    applyStimulus("after_stall",    I_NONE,          E_RUN,     M_ALL);
    // Mul/div occupancy: 1 hold in RUN plus 3 in MD_WAIT
    applyStimulus("md_hold_run",    I_MD,            E_MDHOLD,  M_ALL);
    applyStimulus("md_wait_1",      I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("md_wait_2",      I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("md_wait_3",      I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("md_back_run",    I_NONE,          E_RUN,     M_ALL);
    // Branch alone, then branch together with mul/div
    applyStimulus("branch",         I_BR,            E_BR,      M_ALL);
    applyStimulus("branch_md",      I_BR | I_MD,     E_BRMD,    M_ALL);
    applyStimulus("brmd_wait_1",    I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("brmd_wait_2",    I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("brmd_wait_3",    I_NONE,          E_MDWAIT,  M_ALL);
    // Stop from RUN completes this cycle, then freezes
    applyStimulus("run_stop",       I_STOP,          E_RUN,     M_ALL);
    applyStimulus("stopped_idle",   I_NONE,          E_IDLE,    M_ALL);
    // Single step
    applyStimulus("step_req",       I_STEP,          E_IDLE,    M_ALL);
    applyStimulus("step_cycle",     I_NONE,          E_STEP,    M_ALL);
    applyStimulus("step_done",      I_NONE,          E_IDLE_SD, M_ALL);
    applyStimulus("step_done_end",  I_NONE,          E_IDLE,    M_ALL);
    // Step that starts a mul/div: step_done only after MD_WAIT
    applyStimulus("step_req_md",    I_STEP,          E_IDLE,    M_ALL);
    applyStimulus("step_md_hold",   I_MD,            E_STEPMD,  M_ALL);
    applyStimulus("step_mdwait_1",  I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("step_mdwait_2",  I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("step_mdwait_3",  I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("step_md_done",   I_NONE,          E_IDLE_SD, M_ALL);
    // Stop arriving during a RUN-initiated MD_WAIT returns to IDLE, no pulse
    applyStimulus("idle_run_req2",  I_RUN,           E_IDLE,    M_ALL);
    applyStimulus("run_md",         I_MD,            E_MDHOLD,  M_ALL);
    applyStimulus("mdwait_stop",    I_STOP,          E_MDWAIT,  M_ALL);
    applyStimulus("mdwait_pend_2",  I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("mdwait_pend_3",  I_NONE,          E_MDWAIT,  M_ALL);
    // Run has priority over step
    applyStimulus("run_step_prio",  I_RUN | I_STEP,  E_IDLE,    M_ALL);
    applyStimulus("prio_is_run",    I_NONE,          E_RUN,     M_ALL);
    // HALT behind a load-use stall is deferred, then HALT drains
    applyStimulus("halt_stalled",   I_HALT | I_STALL, E_STALL,  M_ALL);
    applyStimulus("halt_run",       I_HALT,          E_HALTRUN, M_ALL);
    applyStimulus("drain_1",        I_RUN,           E_DRAIN,   M_DRAIN);
    applyStimulus("drain_2",        I_RUN,           E_DRAIN,   M_DRAIN);
    applyStimulus("drain_3",        I_STOP,          E_DRAIN,   M_DRAIN);
    applyStimulus("drain_4",        I_STEP,          E_DRAIN,   M_DRAIN);
    applyStimulus("halted",         I_RUN,           E_HALTED,  M_ALL);
    applyStimulus("halted_run_ign", I_RUN,           E_HALTED,  M_ALL);
    applyStimulus("halted_rst_cyc", I_RST,           E_HALTED,  M_ALL);
    applyStimulus("halt_reset",     I_NONE,          E_IDLE,    M_ALL);
    // Reset during MD_WAIT with a pending stop clears everything
    applyStimulus("idle_run_req3",  I_RUN,           E_IDLE,    M_ALL);
    applyStimulus("run_md2",        I_MD,            E_MDHOLD,  M_ALL);
    applyStimulus("mdwait_stop2",   I_STOP,          E_MDWAIT,  M_ALL);
    applyStimulus("mdwait_rst_cyc", I_RST,           E_MDWAIT,  M_ALL);
    applyStimulus("mdwait_reset",   I_RUN,           E_IDLE,    M_ALL);
    applyStimulus("post_rst_md",    I_MD,            E_MDHOLD,  M_ALL);
    applyStimulus("post_rst_wait1", I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("post_rst_wait2", I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("post_rst_wait3", I_NONE,          E_MDWAIT,  M_ALL);
    applyStimulus("no_stale_stop",  I_NONE,          E_RUN,     M_ALL);

    // Let the monitor consume the last entry
    @(negedge i_clk);
    #1;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain_queue: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
